// File: rtl/fetch_buffer_pkg.sv
// Shared types and constants for the instruction fetch buffer.
package fetch_buffer_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // One queued fetch: the instruction word and its sequential successor address.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc4;
    } fetch_entry_t;

    // Force a fetch target onto a word boundary.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with flush, occupancy count and
// combinational head read. Storage is not reset; only pointers and count are.
module fetch_fifo
    import fetch_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     wr_entry,
    output fetch_entry_t     rd_entry,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    // Entry storage: written at the tail on push, never on a flush edge.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[tail] <= wr_entry;
        end
    end

    // Pointer and count update; flush wins, pointers wrap naturally (DEPTH is a power of two).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Head entry is read straight from storage.
    always_comb begin
        rd_entry = mem[head];
    end

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch stage: owns the fetch PC, fills a small instruction queue
// from a combinational instruction memory and presents the head to IF/ID.
// A redirect flushes the queue and reloads the fetch PC.
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
    localparam int               CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc4,
    output logic [CNT_W-1:0]   occupancy
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] fetch_pc_nxt;
    logic [ADDR_W-1:0] fetch_pc_inc;
    logic              push;
    logic              pop;
    fetch_entry_t      wr_entry;
    fetch_entry_t      head_entry;

    // Queue control: redirect suppresses both push and pop; a full queue
    // accepts a push only when the head leaves on the same edge.
    always_comb begin
        fetch_pc_inc   = fetch_pc + 32'd4;
        out_valid      = (occupancy != '0);
        pop            = out_valid && out_ready && !redirect_valid;
        push           = !redirect_valid && ((occupancy < FULL_CNT) || pop);
        wr_entry.instr = imem_data;
        wr_entry.pc4   = fetch_pc_inc;
        if (redirect_valid) begin
            fetch_pc_nxt = word_align(redirect_pc);
        end else if (push) begin
            fetch_pc_nxt = fetch_pc_inc;
        end else begin
            fetch_pc_nxt = fetch_pc;
        end
    end

    // Fetch PC register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
        end else begin
            fetch_pc <= fetch_pc_nxt;
        end
    end

    // Head presentation: zeroed whenever the queue is empty.
    always_comb begin
        imem_addr = fetch_pc;
        out_instr = '0;
        out_pc4   = '0;
        if (out_valid) begin
            out_instr = head_entry.instr;
            out_pc4   = head_entry.pc4;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .flush    (redirect_valid),
        .wr_entry (wr_entry),
        .rd_entry (head_entry),
        .count    (occupancy)
    );

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed plus randomized bench for fetch_buffer with a queue scoreboard.
module tb_fetch_buffer;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] XMASK    = 32'hA5A5_0000;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc4;
    logic [2:0]  occupancy;

    int total = 0;
    int bad   = 0;

    logic [63:0] sbq[$];
    logic [31:0] m_pc;

    fetch_buffer #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc4        (out_pc4),
        .occupancy      (occupancy)
    );

    assign imem_data = imem_addr ^ XMASK;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [63:0] hd;
        hd = (sbq.size() != 0) ? sbq[0] : 64'd0;
        chk({tag, ".occ"},   32'(occupancy), 32'(sbq.size()));
        chk({tag, ".valid"}, 32'(out_valid), 32'(sbq.size() != 0));
        chk({tag, ".addr"},  imem_addr, m_pc);
        chk({tag, ".instr"}, out_instr, hd[63:32]);
        chk({tag, ".pc4"},   out_pc4, hd[31:0]);
    endtask

    // One clock edge: predict from the model, advance, then compare.
    task automatic step(input string tag);
        logic m_pop;
        logic m_push;
        m_pop  = (sbq.size() != 0) && out_ready && !redirect_valid;
        m_push = !redirect_valid && ((sbq.size() < DEPTH) || m_pop);
        @(posedge clk);
        #1;
        if (redirect_valid) begin
            sbq.delete();
            m_pc = {redirect_pc[31:2], 2'b00};
        end else begin
            if (m_pop) void'(sbq.pop_front());
            if (m_push) begin
                sbq.push_back({m_pc ^ XMASK, m_pc + 32'd4});
                m_pc = m_pc + 32'd4;
            end
        end
        check_outputs(tag);
    endtask

    task automatic model_reset();
        sbq.delete();
        m_pc = RESET_PC;
    endtask

    initial begin
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        out_ready      = 1'b1;
        m_pc           = RESET_PC;

        // Reset state
        #1 rst = 1'b1;
        #1;
        model_reset();
        check_outputs("reset");
        chk("reset.addr_const", imem_addr, RESET_PC);
        #5 rst = 1'b0;

        // Streaming with out_ready high
        step("stream1");
        chk("stream1.pc4", out_pc4, 32'h4);
        chk("stream1.instr", out_instr, 32'hA5A5_0000);
        chk("stream1.occ", 32'(occupancy), 32'd1);
        step("stream2");
        chk("stream2.pc4", out_pc4, 32'h8);
        chk("stream2.instr", out_instr, 32'hA5A5_0004);
        step("stream3");
        chk("stream3.occ", 32'(occupancy), 32'd1);

        // Mid-operation reset, then stall to fill
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_outputs("rst_mid");
        #2 rst = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step("stall");
            chk("stall.occ_const", 32'(occupancy), (i < 4) ? 32'(i + 1) : 32'd4);
        end
        chk("stall.addr_hold", imem_addr, 32'h10);

        // Drain while full: push and pop together
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain.pc4", out_pc4, 32'(4 * (i + 1)));
            step("drain");
            chk("drain.occ_const", 32'(occupancy), 32'd4);
        end

        // Redirect from a full buffer
        out_ready = 1'b0;
        step("refill");
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        step("redir");
        chk("redir.occ", 32'(occupancy), 32'd0);
        chk("redir.valid", 32'(out_valid), 32'd0);
        chk("redir.addr", imem_addr, 32'h200);
        redirect_valid = 1'b0;
        step("redir_tgt");
        chk("redir_tgt.pc4", out_pc4, 32'h204);

        // Redirect coinciding with a ready head: no pop, old head gone
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        step("redir_pop");
        chk("redir_pop.occ", 32'(occupancy), 32'd0);
        redirect_valid = 1'b0;
        step("redir_pop2");
        chk("redir_pop2.pc4", out_pc4, 32'h304);

        // Address wrap at the top of memory
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        step("wrap_redir");
        redirect_valid = 1'b0;
        step("wrap1");
        chk("wrap1.pc4", out_pc4, 32'hFFFF_FFFC);
        chk("wrap1.addr", imem_addr, 32'hFFFF_FFFC);
        step("wrap2");
        chk("wrap2.pc4", out_pc4, 32'h0000_0000);
        chk("wrap2.addr", imem_addr, 32'h0000_0000);
        chk("wrap2.valid", 32'(out_valid), 32'd1);

        // Back-to-back redirects keep the buffer empty
        redirect_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            redirect_pc = 32'h1000 + 32'(i * 32'h41);
            step("b2b");
            chk("b2b.occ", 32'(occupancy), 32'd0);
        end
        redirect_valid = 1'b0;

        // Asynchronous reset with three entries held
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        step("fill_redir");
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) step("fill3");
        chk("fill3.occ", 32'(occupancy), 32'd3);
        #3 rst = 1'b1;
        #1;
        chk("async.valid", 32'(out_valid), 32'd0);
        chk("async.addr", imem_addr, RESET_PC);
        chk("async.occ", 32'(occupancy), 32'd0);
        model_reset();
        #2 rst = 1'b0;
        out_ready = 1'b1;
        step("post_rst");
        chk("post_rst.pc4", out_pc4, RESET_PC + 32'd4);

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            out_ready      = 1'($urandom_range(0, 1));
            redirect_valid = ($urandom_range(0, 7) == 0);
            redirect_pc    = $urandom;
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
